// File: rtl/avsd_dpll_pkg.sv
// Shared definitions for the AVSD DPLL/NCO block.
//   - Default parameter constants used by avsd_dpll_nco.
//   - FSM state encoding, also visible on the top-level dbg_state port.
package avsd_dpll_pkg;

    localparam int AW_DEF       = 24;  // NCO accumulator / step width
    localparam int CW_DEF       = 16;  // REF period counter width
    localparam int MW_DEF       = 6;   // multiplication factor width
    localparam int LOCK_N_DEF   = 4;   // matched periods needed for lock
    localparam int LOCK_TOL_DEF = 2;   // period tolerance in sys cycles

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,  // disabled, everything cleared
        ST_ACQ  = 2'd1,  // waiting for the first REF edge
        ST_MEAS = 2'd2,  // counting, no valid step yet
        ST_RUN  = 2'd3   // step valid, accumulator running
    } dpll_state_e;

endpackage

// File: rtl/avsd_seq_div.sv
// Restartable unsigned restoring divider, one quotient bit per cycle.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : load dividend/divisor and begin; restarts a divide in flight
//   abort       : drop any divide in flight (wins over start)
//   dividend    : DW-bit numerator, sampled on start
//   divisor     : VW-bit denominator, sampled on start
//   done        : one-cycle pulse DW cycles after the start cycle
//   quotient    : result, valid while done is high and held until next start
//
// Handshake: start and abort are single-cycle requests with no back-pressure;
// done is the only response and is suppressed for any aborted or restarted
// divide, so a done pulse always belongs to the most recent start.
module avsd_seq_div #(
    parameter int DW = 30,
    parameter int VW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          done,
    output logic [DW-1:0] quotient
);

    localparam int CNTW = $clog2(DW + 1);

    logic [DW-1:0]   quo_q, quo_d;
    logic [VW-1:0]   rem_q, rem_d;
    logic [VW-1:0]   den_q, den_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [VW:0]     trial;

    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        den_d  = den_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        // Partial remainder shifted left with the next dividend bit; the
        // dividend bits are consumed from the top of the quotient register.
        trial  = {rem_q, quo_q[DW-1]};

        if (abort) begin
            busy_d = 1'b0;
        end else if (start) begin
            quo_d  = dividend;
            rem_d  = '0;
            den_d  = divisor;
            cnt_d  = CNTW'(DW);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (trial >= {1'b0, den_q}) begin
                rem_d = VW'(trial - {1'b0, den_q});
                quo_d = {quo_q[DW-2:0], 1'b1};
            end else begin
                rem_d = trial[VW-1:0];
                quo_d = {quo_q[DW-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNTW'(1);
            if (cnt_q == CNTW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            den_q  <= den_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/avsd_dpll_nco.sv
// Frequency-locking NCO: measures the REF period in CLK cycles, divides
// (MULT << AW) by it to get a phase step, and runs a phase accumulator whose
// MSB is the generated clock.
//
// Ports:
//   CLK, RSTn : system clock, asynchronous active-low reset
//   REF       : reference clock, asynchronous to CLK
//   ENb       : active-low enable; high forces OFF on the next cycle
//   MULT      : output/reference frequency ratio, sampled at each divide start
//   CLK_OUT   : generated clock (accumulator MSB)
//   LOCK      : frequency lock (RUN, full match count, non-zero step)
//   PERIOD    : last captured REF period in CLK cycles
//   STEP      : current NCO phase step
//   dbg_state : current FSM state (dpll_state_e encoding)
module avsd_dpll_nco
    import avsd_dpll_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int CW       = CW_DEF,
    parameter int MW       = MW_DEF,
    parameter int LOCK_N   = LOCK_N_DEF,
    parameter int LOCK_TOL = LOCK_TOL_DEF
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          REF,
    input  logic          ENb,
    input  logic [MW-1:0] MULT,
    output logic          CLK_OUT,
    output logic          LOCK,
    output logic [CW-1:0] PERIOD,
    output logic [AW-1:0] STEP,
    output logic [1:0]    dbg_state
);

    localparam int MCW = $clog2(LOCK_N + 1);
    localparam logic [AW-1:0] STEP_MAX = AW'(1) << (AW - 1);

    dpll_state_e    state_q, state_d;
    logic           ref_s1_q, ref_s1_d;
    logic           ref_s2_q, ref_s2_d;
    logic           ref_d_q, ref_d_d;
    logic [1:0]     arm_q, arm_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  period_q, period_d;
    logic [AW-1:0]  step_q, step_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic [MCW-1:0] match_q, match_d;
    logic           lock_q, lock_d;

    logic           ref_edge;
    logic           sat;
    logic [CW-1:0]  per_diff;
    logic           per_match;
    logic           div_start, div_abort, div_done;
    logic [MW+AW-1:0] div_quo;
    logic [AW-1:0]  step_new;

    avsd_seq_div #(
        .DW(MW + AW),
        .VW(CW)
    ) u_div (
        .clk      (CLK),
        .rst_n    (RSTn),
        .start    (div_start),
        .abort    (div_abort),
        .dividend ({MULT, {AW{1'b0}}}),
        .divisor  (cnt_q),
        .done     (div_done),
        .quotient (div_quo)
    );

    // Edges are ignored until the synchroniser has refilled after reset, so
    // a REF already high at reset release is not taken as an edge.
    assign ref_edge  = (arm_q == 2'd3) && ref_s2_q && !ref_d_q;
    assign sat       = &cnt_q;
    assign per_diff  = (cnt_q >= period_q) ? (cnt_q - period_q) : (period_q - cnt_q);
    assign per_match = (per_diff <= CW'(LOCK_TOL));
    // Clamp keeps the output at or below CLK/2.
    assign step_new  = (div_quo > {{MW{1'b0}}, STEP_MAX}) ? STEP_MAX : div_quo[AW-1:0];

    always_comb begin
        ref_s1_d  = REF;
        ref_s2_d  = ref_s1_q;
        ref_d_d   = ref_s2_q;
        arm_d     = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        step_d    = step_q;
        acc_d     = acc_q;
        match_d   = match_q;
        div_start = 1'b0;
        div_abort = 1'b0;

        if (ENb) begin
            state_d   = ST_OFF;
            cnt_d     = '0;
            period_d  = '0;
            step_d    = '0;
            acc_d     = '0;
            match_d   = '0;
            div_abort = 1'b1;
        end else begin
            case (state_q)
                ST_OFF: state_d = ST_ACQ;
                ST_ACQ: begin
                    if (ref_edge) begin
                        state_d = ST_MEAS;
                        cnt_d   = CW'(1);
                    end
                end
                default: begin
                    // Counter saturation means REF is gone; it overrides a
                    // coincident edge.
                    if (sat) begin
                        state_d   = ST_ACQ;
                        cnt_d     = '0;
                        period_d  = '0;
                        step_d    = '0;
                        acc_d     = '0;
                        match_d   = '0;
                        div_abort = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (state_q == ST_RUN) begin
                            // A zero step parks the accumulator so CLK_OUT stays low.
                            acc_d = (step_q == '0) ? '0 : acc_q + step_q;
                        end
                        if (div_done) begin
                            step_d  = step_new;
                            state_d = ST_RUN;
                        end
                        if (ref_edge) begin
                            period_d  = cnt_q;
                            cnt_d     = CW'(1);
                            div_start = 1'b1;
                            if (per_match) begin
                                match_d = (match_q == MCW'(LOCK_N)) ? match_q : match_q + MCW'(1);
                            end else begin
                                match_d = '0;
                            end
                        end
                    end
                end
            endcase
        end

        lock_d = (state_d == ST_RUN) && (match_d == MCW'(LOCK_N)) && (step_d != '0);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= ST_OFF;
            ref_s1_q <= 1'b0;
            ref_s2_q <= 1'b0;
            ref_d_q  <= 1'b0;
            arm_q    <= 2'd0;
            cnt_q    <= '0;
            period_q <= '0;
            step_q   <= '0;
            acc_q    <= '0;
            match_q  <= '0;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ref_s1_q <= ref_s1_d;
            ref_s2_q <= ref_s2_d;
            ref_d_q  <= ref_d_d;
            arm_q    <= arm_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            step_q   <= step_d;
            acc_q    <= acc_d;
            match_q  <= match_d;
            lock_q   <= lock_d;
        end
    end

    assign CLK_OUT   = acc_q[AW-1];
    assign LOCK      = lock_q;
    assign PERIOD    = period_q;
    assign STEP      = step_q;
    assign dbg_state = state_q;

endmodule

// File: doc/avsd_dpll_nco.md
AVSD_DPLL_NCO -- requirements
Module: avsd_dpll_nco

Interface
REQ-001: Parameter AW, default 24, NCO phase-accumulator and step width in bits.
REQ-002: Parameter CW, default 16, REF-period counter width in sys cycles.
REQ-003: Parameter MW, default 6, multiplication-factor width.
REQ-004: Parameter LOCK_N, default 4, consecutive matching REF periods required for lock.
REQ-005: Parameter LOCK_TOL, default 2, maximum period difference, in sys cycles, counted as a match.
REQ-006: CLK  input  1  system clock; all logic on its rising edge; one clock domain.
REQ-007: RSTn  input  1  asynchronous, active-low reset.
REQ-008: REF  input  1  reference clock, asynchronous to CLK.
REQ-009: ENb  input  1  active-low enable; 1 forces the OFF state.
REQ-010: MULT  input  MW  output/reference frequency ratio, sampled at each divide start.
REQ-011: CLK_OUT  output  1  generated clock, equal to the accumulator MSB.
REQ-012: LOCK  output  1  frequency-lock indicator.
REQ-013: PERIOD  output  CW  last captured REF period in sys cycles.
REQ-014: STEP  output  AW  current NCO phase step.

Function
REQ-015: REF shall pass through a 2-flop synchroniser plus an edge register; a rising edge is a 0->1 transition of the synchronised signal, 3 CLK cycles of latency.
REQ-016: FSM states: OFF, ACQ (wait for first edge), MEAS (counting, no valid step), RUN (valid step).
REQ-017: ENb=1 in any state -> OFF next cycle: counter, accumulator, STEP, PERIOD, match count cleared; CLK_OUT=0; LOCK=0.
REQ-018: OFF -> ACQ when ENb=0; ACQ -> MEAS on the first REF edge, counter loaded with 1.
REQ-019: Counter increments every cycle in MEAS/RUN; on each subsequent edge, counter value -> PERIOD, counter reloads 1, and a divide starts.
REQ-020: Divide computes STEP_new = floor((MULT << AW) / PERIOD), dividend width MW+AW, latency MW+AW+1 cycles from edge to STEP update.
REQ-021: STEP_new > 2^(AW-1) shall clamp to 2^(AW-1), so CLK_OUT never exceeds CLK/2.
REQ-022: MULT=0 -> STEP=0, CLK_OUT held low, LOCK=0.
REQ-023: A REF edge while the divider is busy shall abort it and restart it with the new PERIOD; STEP keeps its old value until a divide completes.
REQ-024: First divide completion: MEAS -> RUN; the accumulator adds STEP every cycle modulo 2^AW.
REQ-025: Counter reaching 2^CW-1 (REF lost) shall produce: PERIOD=0, STEP=0, LOCK=0, match count=0, accumulator cleared, state ACQ.
REQ-026: A capture with |PERIOD_new - PERIOD_old| <= LOCK_TOL shall increment the match count (saturating at LOCK_N); otherwise the match count resets to 0 and LOCK drops the next cycle.
REQ-027: LOCK=1 iff state RUN, match count = LOCK_N and STEP != 0.
REQ-028: Simultaneous REF edge and counter saturation: saturation wins.

Reset
REQ-029: RSTn=0 shall asynchronously force state OFF, all registers 0, CLK_OUT=0, LOCK=0, PERIOD=0, STEP=0.
REQ-030: On RSTn deassertion, the synchroniser shall discard any REF edge within the first 3 cycles.

Structure
REQ-031: Package avsd_dpll_pkg shall hold the FSM state enum and the default parameter constants.
REQ-032: Submodule avsd_seq_div: restartable unsigned restoring divider with start/abort/done handshake and parametrised width.
REQ-033: Target size 150-300 RTL lines; no real-valued or delay constructs; synthesizable.

Verification
REQ-034: REF period 64 CLK, MULT=8 -> PERIOD=64, STEP=2^21, CLK_OUT period 8 CLK with 50% duty.
REQ-035: Same stimulus, steady -> LOCK=1 after the 6th REF edge (4 matches); period jumps to 80 -> LOCK=0; re-asserts after 4 more matched edges.
REQ-036: REF period 16, MULT=16 -> STEP clamped to 2^23, CLK_OUT=CLK/2.
REQ-037: REF stopped in RUN -> after 65535 cycles PERIOD=0, STEP=0, LOCK=0, CLK_OUT=0, state ACQ; REF restart relocks.
REQ-038: REF period 20 (< divide latency 31) -> repeated abort/restart, STEP unchanged, no X on outputs.
REQ-039: ENb toggled to 1, or RSTn pulsed low, mid-RUN -> all outputs 0 immediately (RSTn) or next cycle (ENb); re-enable restarts from ACQ.
